// File: rtl/pwm_duty_update_scheduler.sv
// Buffers host duty commands in per-phase shadow registers and moves a committed
// batch into the active duty registers atomically at a carrier turning point.
module pwm_duty_update_scheduler #(
  parameter int WIDTH_TRIANG = 6,
  parameter int N_PH         = 4,
  parameter int UPDATE_MODE  = 0,
  localparam int PH_W        = (N_PH > 1) ? $clog2(N_PH) : 1,
  localparam int DW          = WIDTH_TRIANG + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_TRIANG-1:0] carrier,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [PH_W-1:0]        cmd_phase,
  input  logic [DW-1:0]          cmd_duty,
  input  logic                   cmd_commit,
  output logic [N_PH*DW-1:0]     duty_active,
  output logic                   update_pulse,
  output logic                   pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } state_t;

  localparam logic [DW-1:0] DUTY_MAX = {1'b1, {WIDTH_TRIANG{1'b0}}};

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   shadow [N_PH];
  logic [DW-1:0]   active [N_PH];
  logic [DW-1:0]   duty_clamped;
  logic            carrier_valley;
  logic            carrier_peak;
  logic            evt;
  logic            accept;
  logic            apply;

  assign carrier_valley = ~|carrier;
  assign carrier_peak   = &carrier;
  assign evt            = carrier_valley || ((UPDATE_MODE != 0) && carrier_peak);

  // Handshake outputs come from the state register only, never from cmd_valid.
  assign cmd_ready = (state != ARMED);
  assign pending   = (state == ARMED);

  assign accept       = cmd_valid && cmd_ready;
  assign apply        = (state == ARMED) && evt;
  assign duty_clamped = (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make the result depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default first so no path through the case can
  // leave it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, LOADING: begin
        // A commit in the same cycle as evt only arms; that event is not used.
        if (cmd_valid) state_next = cmd_commit ? ARMED : LOADING;
      end
      ARMED: begin
        if (evt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: shadow/active are small flop arrays, not RAM, so they take the async
  // clear; a reset must leave the comparators with a known zero duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_PH; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= apply;
      for (int k = 0; k < N_PH; k++) begin
        // Out-of-range phase indices match no k, so the write is simply dropped.
        if (accept && (cmd_phase == PH_W'(k))) shadow[k] <= duty_clamped;
        if (apply) active[k] <= shadow[k];
      end
    end
  end

  for (genvar g = 0; g < N_PH; g++) begin : g_pack
    assign duty_active[g*DW +: DW] = active[g];
  end

endmodule

// File: tb/tb_pwm_duty_update_scheduler.sv
// Directed bench: a mode-0/4-phase instance for the main flow and a
// mode-1/5-phase instance for peak updates and out-of-range phase writes.
module tb_pwm_duty_update_scheduler;

  localparam int W = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [W-1:0] carrier = '0;
  bit         up = 1'b1;

  logic       cmd_valid0 = 1'b0, cmd_commit0 = 1'b0, cmd_ready0;
  logic [1:0] cmd_phase0 = '0;
  logic [6:0] cmd_duty0 = '0;
  logic [27:0] duty0;
  logic       pulse0, pending0;

  logic       cmd_valid1 = 1'b0, cmd_commit1 = 1'b0, cmd_ready1;
  logic [2:0] cmd_phase1 = '0;
  logic [6:0] cmd_duty1 = '0;
  logic [34:0] duty1;
  logic       pulse1, pending1;

  int n_checks = 0;
  int n_errors = 0;

  pwm_duty_update_scheduler #(.WIDTH_TRIANG(W), .N_PH(4), .UPDATE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .carrier(carrier),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_phase(cmd_phase0),
    .cmd_duty(cmd_duty0), .cmd_commit(cmd_commit0),
    .duty_active(duty0), .update_pulse(pulse0), .pending(pending0)
  );

  pwm_duty_update_scheduler #(.WIDTH_TRIANG(W), .N_PH(5), .UPDATE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .carrier(carrier),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_phase(cmd_phase1),
    .cmd_duty(cmd_duty1), .cmd_commit(cmd_commit1),
    .duty_active(duty1), .update_pulse(pulse1), .pending(pending1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int d0, input int d1, input int d2, input int d3);
    return (64'(d0)) | (64'(d1) << 7) | (64'(d2) << 14) | (64'(d3) << 21);
  endfunction

  // One clock edge; afterwards outputs reflect that edge and carrier holds the
  // value the next edge will see (standard up/down triangle generator).
  task automatic tick();
    @(posedge clk);
    #1;
    if (up) begin
      if (carrier == 6'd63) begin up = 1'b0; carrier = 6'd62; end
      else carrier = carrier + 6'd1;
    end else begin
      if (carrier == 6'd0) begin up = 1'b1; carrier = 6'd1; end
      else carrier = carrier - 6'd1;
    end
  endtask

  // d: 0 = falling, 1 = rising, 2 = either
  task automatic wait_carrier(input int v, input int d);
    int n = 0;
    while (!(int'(carrier) == v && (d == 2 || int'(up) == d)) && n < 300) begin
      tick();
      n++;
    end
    check("wait_carrier_timeout", 64'(n < 300), 64'd1);
  endtask

  task automatic send0(input logic [1:0] ph, input logic [6:0] duty, input logic commit);
    cmd_valid0 = 1'b1; cmd_phase0 = ph; cmd_duty0 = duty; cmd_commit0 = commit;
    tick();
    cmd_valid0 = 1'b0; cmd_commit0 = 1'b0;
  endtask

  task automatic send1(input logic [2:0] ph, input logic [6:0] duty, input logic commit);
    cmd_valid1 = 1'b1; cmd_phase1 = ph; cmd_duty1 = duty; cmd_commit1 = commit;
    tick();
    cmd_valid1 = 1'b0; cmd_commit1 = 1'b0;
  endtask

  // Edges until update_pulse of the selected instance; reports the carrier seen
  // at the apply edge and the duty vector just before it.
  task automatic wait_pulse(input bit sel, output int n, output int c_at, output logic [63:0] prev);
    int cur;
    n = 0; c_at = -1; prev = '0;
    while (n < 300) begin
      cur  = int'(carrier);
      prev = sel ? 64'(duty1) : 64'(duty0);
      tick();
      n++;
      if ((sel ? pulse1 : pulse0) === 1'b1) begin
        c_at = cur;
        break;
      end
    end
    check("wait_pulse_timeout", 64'(n < 300), 64'd1);
  endtask

  initial begin
    int n, c_at;
    logic [63:0] prev;
    bit flag;

    // Reset
    tick(); tick();
    check("rst_duty0", 64'(duty0), 64'd0);
    check("rst_pulse0", 64'(pulse0), 64'd0);
    check("rst_pending0", 64'(pending0), 64'd0);
    #2 rst = 1'b0;
    tick();
    check("rst_ready0", 64'(cmd_ready0), 64'd1);
    check("rst_ready1", 64'(cmd_ready1), 64'd1);

    // Single update: phase 2 = 40 committed at carrier 10 rising
    wait_carrier(10, 1);
    send0(2'd2, 7'd40, 1'b1);
    check("single_pending", 64'(pending0), 64'd1);
    check("single_ready", 64'(cmd_ready0), 64'd0);
    check("single_no_early", 64'(duty0), 64'd0);
    wait_pulse(0, n, c_at, prev);
    check("single_latency", 64'(n), 64'd116);
    check("single_carrier", 64'(c_at), 64'd0);
    check("single_prev", prev, 64'd0);
    check("single_duty", 64'(duty0), pack4(0, 0, 40, 0));
    check("single_pending_clr", 64'(pending0), 64'd0);
    tick();
    check("single_pulse_1cyc", 64'(pulse0), 64'd0);
    check("single_duty_hold", 64'(duty0), pack4(0, 0, 40, 0));

    // Atomic batch, valley crossed between beats 1 and 2
    wait_carrier(2, 0);
    send0(2'd0, 7'd10, 1'b0);
    flag = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (pulse0 !== 1'b0 || duty0 !== 28'(pack4(0, 0, 40, 0))) flag = 1'b1;
    end
    check("batch_valley_ignored", 64'(flag), 64'd0);
    send0(2'd1, 7'd20, 1'b0);
    send0(2'd2, 7'd30, 1'b0);
    send0(2'd3, 7'd64, 1'b1);
    wait_pulse(0, n, c_at, prev);
    check("batch_latency", 64'(n), 64'd123);
    check("batch_carrier", 64'(c_at), 64'd0);
    check("batch_prev", prev, pack4(0, 0, 40, 0));
    check("batch_duty", 64'(duty0), pack4(10, 20, 30, 64));

    // Commit beat in the carrier==0 cycle: that valley is skipped
    wait_carrier(0, 2);
    send0(2'd0, 7'd5, 1'b1);
    check("valley_commit_no_pulse", 64'(pulse0), 64'd0);
    check("valley_commit_pending", 64'(pending0), 64'd1);
    wait_pulse(0, n, c_at, prev);
    check("valley_commit_latency", 64'(n), 64'd126);
    check("valley_commit_duty", 64'(duty0), pack4(5, 20, 30, 64));

    // Clamp: 100 -> 64
    send0(2'd1, 7'd100, 1'b1);
    wait_pulse(0, n, c_at, prev);
    check("clamp_latency", 64'(n), 64'd125);
    check("clamp_duty", 64'(duty0), pack4(5, 64, 30, 64));

    // Backpressure: beat held through ARMED, accepted after apply, shadow only
    send0(2'd3, 7'd20, 1'b1);
    cmd_valid0 = 1'b1; cmd_phase0 = 2'd0; cmd_duty0 = 7'd7; cmd_commit0 = 1'b0;
    flag = 1'b0;
    n = 0;
    while (n < 300) begin
      if (cmd_ready0 !== 1'b0) flag = 1'b1;
      tick();
      n++;
      if (pulse0 === 1'b1) break;
    end
    check("bp_ready_low", 64'(flag), 64'd0);
    check("bp_latency", 64'(n), 64'd125);
    check("bp_duty", 64'(duty0), pack4(5, 64, 30, 20));
    check("bp_ready_after", 64'(cmd_ready0), 64'd1);
    tick();
    cmd_valid0 = 1'b0;
    check("bp_no_pending", 64'(pending0), 64'd0);
    flag = 1'b0;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (pulse0 !== 1'b0 || duty0 !== 28'(pack4(5, 64, 30, 20))) flag = 1'b1;
    end
    check("bp_uncommitted_held", 64'(flag), 64'd0);
    send0(2'd2, 7'd30, 1'b1);
    wait_pulse(0, n, c_at, prev);
    check("bp_shadow_landed", 64'(duty0), pack4(7, 64, 30, 20));

    // UPDATE_MODE=1, out-of-range phase 5 on the 5-phase instance
    wait_carrier(5, 1);
    send1(3'd5, 7'd33, 1'b1);
    check("m1_pending", 64'(pending1), 64'd1);
    wait_pulse(1, n, c_at, prev);
    check("m1_latency", 64'(n), 64'd58);
    check("m1_carrier_peak", 64'(c_at), 64'd63);
    check("m1_oob_no_change", 64'(duty1), 64'd0);
    send1(3'd4, 7'd64, 1'b1);
    wait_pulse(1, n, c_at, prev);
    check("m1_valley_latency", 64'(n), 64'd62);
    check("m1_carrier_valley", 64'(c_at), 64'd0);
    check("m1_duty", 64'(duty1), 64'd64 << 28);

    // Reset while ARMED discards the batch
    send0(2'd1, 7'd9, 1'b1);
    tick(); tick(); tick();
    check("mr_pending_before", 64'(pending0), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_duty0", 64'(duty0), 64'd0);
    check("mr_duty1", 64'(duty1), 64'd0);
    check("mr_pulse0", 64'(pulse0), 64'd0);
    check("mr_pending0", 64'(pending0), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("mr_ready_after", 64'(cmd_ready0), 64'd1);
    check("mr_pending_after", 64'(pending0), 64'd0);
    flag = 1'b0;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (pulse0 !== 1'b0 || duty0 !== 28'd0) flag = 1'b1;
    end
    check("mr_batch_discarded", 64'(flag), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
